// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Adds two W = N*K bit operands using one shared N-bit adder slice.
//   One slice is processed per clock, LSB slice first, with the slice carry
//   held in a register between cycles. Operands arrive on a valid/ready
//   request port; the result leaves on a valid/ready response port.
//
//   Optional feature macro: WIDE_ADD_SUB_EN
//     When defined, adds input 'sub'. With sub=1 the block computes a - b
//     (B captured inverted, carry-in forced to 1). c_out=1 then means no borrow.
//
// Ports
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   s_valid  in   operand request valid
//   s_ready  out  ready for operands (IDLE only)
//   a, b     in   W-bit operands, sampled on accept
//   c_in     in   carry into slice 0, sampled on accept
//   sub      in   (WIDE_ADD_SUB_EN only) subtract select, sampled on accept
//   m_valid  out  result valid
//   m_ready  in   result sink ready
//   sum      out  W-bit registered result
//   c_out    out  registered carry out of the top slice
module wide_add_sequencer #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           c_in,
`ifdef WIDE_ADD_SUB_EN
  input  logic           sub,
`endif
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*K-1:0] sum,
  output logic           c_out
);

  localparam int W  = N * K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          c_out_q, c_out_d;
  logic          m_valid_q, m_valid_d;

  // Operand B / carry as they enter the registers; subtraction is a + ~b + 1.
  logic [W-1:0]  b_in;
  logic          carry_in;
`ifdef WIDE_ADD_SUB_EN
  assign b_in     = sub ? ~b : b;
  assign carry_in = sub ? 1'b1 : c_in;
`else
  assign b_in     = b;
  assign carry_in = c_in;
`endif

  // Shared slice adder, fed by the slice the counter points at.
  logic [N-1:0] sl_a, sl_b, sl_sum;
  logic         sl_co;
  assign sl_a = a_q[cnt_q*N +: N];
  assign sl_b = b_q[cnt_q*N +: N];
  assign {sl_co, sl_sum} = {1'b0, sl_a} + {1'b0, sl_b} + {{N{1'b0}}, carry_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    m_valid_d = m_valid_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[cnt_q*N +: N] = sl_sum;
        carry_d             = sl_co;
        if (cnt_q == CNT_LAST) begin
          c_out_d   = sl_co;
          m_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Ready decodes the state register only: no path from s_valid or m_ready.
  assign s_ready = (state_q == IDLE);
  assign m_valid = m_valid_q;
  assign sum     = sum_q;
  assign c_out   = c_out_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid, s_ready, c_in, sub, m_valid, m_ready, c_out;
  logic [31:0] a, b, sum;

  // K=1 instance for the single-slice boundary case
  logic        k1_s_valid, k1_s_ready, k1_c_in, k1_sub, k1_m_valid, k1_m_ready, k1_c_out;
  logic [7:0]  k1_a, k1_b, k1_sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  wide_add_sequencer #(.N(8), .K(4)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .a(a), .b(b), .c_in(c_in),
`ifdef WIDE_ADD_SUB_EN
    .sub(sub),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .sum(sum), .c_out(c_out)
  );

  wide_add_sequencer #(.N(8), .K(1)) dut_k1 (
    .clk(clk), .rstn(rstn), .s_valid(k1_s_valid), .s_ready(k1_s_ready),
    .a(k1_a), .b(k1_b), .c_in(k1_c_in),
`ifdef WIDE_ADD_SUB_EN
    .sub(k1_sub),
`endif
    .m_valid(k1_m_valid), .m_ready(k1_m_ready), .sum(k1_sum), .c_out(k1_c_out)
  );

  function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    if (sb) return {1'b0, av} + {1'b0, ~bv} + 33'd1;
    return {1'b0, av} + {1'b0, bv} + {32'd0, ci};
  endfunction

  // Drive one request from a negedge in IDLE; returns at the negedge of cycle 1.
  // Inputs are scrambled afterwards so a late change would corrupt the result.
  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    s_valid = 1'b1; a = av; b = bv; c_in = ci; sub = sb;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
  endtask

  // Wait (bounded) for m_valid; lat counts cycles from the accept cycle.
  task automatic wait_valid(output int lat, output bit timed_out);
    lat = 1;
    while (!m_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !m_valid;
  endtask

  task automatic take();
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_valid = 0; a = '0; b = '0; c_in = 0; sub = 0; m_ready = 0;
    k1_s_valid = 0; k1_a = '0; k1_b = '0; k1_c_in = 0; k1_sub = 0; k1_m_ready = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_ready, m_valid, c_out, sum} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b c_out=%b sum=%h, want 1 0 0 00000000",
               s_ready, m_valid, c_out, sum);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_chain();
    int lat; bit to; logic [32:0] e;
    m_ready = 1'b1;  // held high through RUN: must be ignored there
    exp_q.push_back(model(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0));
    send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
    wait_valid(lat, to);
    n_checks++;
    if (to || lat != 5) begin
      n_fail++; $display("FAIL carry_latency: got %0d (timeout=%0d), want 5", lat, to);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({c_out, sum} !== e) begin
      n_fail++; $display("FAIL carry_chain: got %h, want %h", {c_out, sum}, e);
    end
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL carry_release: m_valid=%b s_ready=%b, want 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_cin_boundary();
    int lat; bit to; logic [32:0] e; bit rdy_bad;
    exp_q.push_back(model(32'h000000FF, 32'h0, 1'b1, 1'b0));
    send(32'h000000FF, 32'h0, 1'b1, 1'b0);
    rdy_bad = 1'b0;
    lat = 1;
    while (!m_valid && lat < 40) begin
      if (s_ready !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (s_ready !== 1'b0) rdy_bad = 1'b1;
    n_checks++;
    if (rdy_bad || !m_valid) begin
      n_fail++; $display("FAIL cin_ready_low: s_ready seen high in flight or no result (m_valid=%b)", m_valid);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({c_out, sum} !== e) begin
      n_fail++; $display("FAIL cin_boundary: got %h, want %h", {c_out, sum}, e);
    end
    take();
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL cin_ready_back: s_ready=%b, want 1", s_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; logic [32:0] e, e2; bit hold_bad;
    exp_q.push_back(model(32'h12345678, 32'h11111111, 1'b0, 1'b0));
    send(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    // second request presented while the first result is stalled
    s_valid = 1'b1; a = 32'h00000010; b = 32'h00000020; c_in = 1'b1; sub = 1'b0;
    e2 = model(32'h10, 32'h20, 1'b1, 1'b0);
    hold_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || {c_out, sum} !== e) hold_bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (to || hold_bad || {c_out, sum} !== e) begin
      n_fail++; $display("FAIL backpressure_hold: got %h m_valid=%b s_ready=%b, want %h 1 0",
                         {c_out, sum}, m_valid, s_ready, e);
    end
    take();
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: s_ready=%b m_valid=%b, want 1 0", s_ready, m_valid);
    end
    exp_q.push_back(e2);
    @(posedge clk);  // second request accepted here
    @(negedge clk);
    s_valid = 1'b0; a = $urandom; b = $urandom;
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || lat != 5 || {c_out, sum} !== e) begin
      n_fail++; $display("FAIL backpressure_second: got %h lat=%0d, want %h lat=5", {c_out, sum}, lat, e);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int lat; bit to; logic [32:0] e;
    send(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0);
    @(negedge clk);  // cycle 2: mid-RUN
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({m_valid, c_out, sum} !== 34'h0) begin
      n_fail++; $display("FAIL reset_mid_clear: m_valid=%b c_out=%b sum=%h, want 0 0 00000000", m_valid, c_out, sum);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || sum !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_idle: s_ready=%b m_valid=%b sum=%h, want 1 0 0", s_ready, m_valid, sum);
    end
    exp_q.push_back(model(32'h1, 32'h2, 1'b0, 1'b0));
    send(32'h1, 32'h2, 1'b0, 1'b0);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {c_out, sum} !== e) begin
      n_fail++; $display("FAIL reset_mid_next: got %h, want %h", {c_out, sum}, e);
    end
    take();
  endtask

  task automatic test_k1();
    int lat;
    k1_s_valid = 1'b1; k1_a = 8'h80; k1_b = 8'h80; k1_c_in = 1'b1; k1_sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    k1_s_valid = 1'b0; k1_a = 8'h00; k1_b = 8'h00; k1_c_in = 1'b0;
    lat = 1;
    while (!k1_m_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 2 || {k1_c_out, k1_sum} !== 9'h101) begin
      n_fail++; $display("FAIL k1_boundary: got %h lat=%0d, want 101 lat=2", {k1_c_out, k1_sum}, lat);
    end
    k1_m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k1_m_ready = 1'b0;
    n_checks++;
    if (k1_m_valid !== 1'b0 || k1_s_ready !== 1'b1) begin
      n_fail++; $display("FAIL k1_release: m_valid=%b s_ready=%b, want 0 1", k1_m_valid, k1_s_ready);
    end
  endtask

  task automatic test_random();
    int lat; bit to; logic [32:0] e; logic [31:0] av, bv; logic ci;
    for (int i = 0; i < 6; i++) begin
      av = $urandom; bv = $urandom; ci = 1'($urandom);
      if (i == 0) begin av = 32'h0; bv = 32'h0; ci = 1'b0; end
      exp_q.push_back(model(av, bv, ci, 1'b0));
      send(av, bv, ci, 1'b0);
      wait_valid(lat, to);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (to || {c_out, sum} !== e) begin
        n_fail++; $display("FAIL random_%0d: got %h, want %h", i, {c_out, sum}, e);
      end
      take();
    end
  endtask

`ifdef WIDE_ADD_SUB_EN
  task automatic test_sub();
    int lat; bit to; logic [32:0] e;
    exp_q.push_back({1'b0, 32'hFFFFFFFE});
    send(32'd5, 32'd7, 1'b0, 1'b1);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {c_out, sum} !== e) begin
      n_fail++; $display("FAIL sub_borrow: got %h, want %h", {c_out, sum}, e);
    end
    take();
    exp_q.push_back({1'b1, 32'h00000002});
    send(32'd7, 32'd5, 1'b0, 1'b1);
    wait_valid(lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || {c_out, sum} !== e) begin
      n_fail++; $display("FAIL sub_noborrow: got %h, want %h", {c_out, sum}, e);
    end
    take();
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_cin_boundary();
    test_backpressure();
    test_reset_mid();
    test_k1();
    test_random();
`ifdef WIDE_ADD_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
